// File: rtl/accum_arb_pkg.sv
// accum_arb_pkg: shared types and default sizes for the burst arbiter and its
// tag FIFO.
package accum_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int NREQ_DEF   = 4;
  localparam int DATAW_DEF  = 19;
  localparam int ACCUMW_DEF = 32;
  localparam int LENW_DEF   = 8;
  localparam int TAGD_DEF   = 4;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/accum_arb_tag.sv
// tag_fifo: small circular FIFO holding the requester index of every burst
// whose accumulator result has not come back yet.
module tag_fifo
  import accum_arb_pkg::*;
#(
  parameter int DEPTH = TAGD_DEF,
  parameter int W     = ID_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot, so a push into a full FIFO succeeds when paired with one.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  // Storage is not reset: entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/accum_arb.sv
// accum_arb: round-robin burst arbiter in front of a shared accumulator.
// One requester owns the accumulator for cfg_len beats; the owner's index is
// queued as a tag so each accumulator result is routed back to its burst owner.
module accum_arb
  import accum_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATAW  = DATAW_DEF,
  parameter int ACCUMW = ACCUMW_DEF,
  parameter int LENW   = LENW_DEF,
  parameter int TAGD   = TAGD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LENW-1:0]           cfg_len,
  input  logic [NREQ*DATAW-1:0]     req_data,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  output logic [DATAW-1:0]          acc_data,
  output logic                      acc_ivalid,
  output logic                      acc_first,
  output logic                      acc_last,
  input  logic [ACCUMW-1:0]         acc_result,
  input  logic                      acc_ovalid,
  output logic [ACCUMW-1:0]         res_data,
  output logic [id_width(NREQ)-1:0] res_id,
  output logic                      res_valid,
  output logic                      busy,
  output logic                      err_orphan
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(TAGD + 1);

  state_e                  state_q;
  logic [IDW-1:0]          grant_q, last_q, pick;
  logic                    pick_vld;
  logic [LENW-1:0]         len_q, cnt_q, len_d;
  logic signed [DATAW-1:0] beat_data, acc_data_q;
  logic                    beat_vld, beat_last;
  logic                    acc_ivalid_q, acc_first_q, acc_last_q;
  logic                    tag_push, tag_pop, tag_full, tag_empty;
  logic [IDW-1:0]          tag_head;
  logic [CW-1:0]           tag_count;
  logic [ACCUMW-1:0]       res_data_q;
  logic [IDW-1:0]          res_id_q;
  logic                    res_valid_q, err_orphan_q;

  // Round-robin search: scan downward so the nearest index after last_q wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IDW'((int'(last_q) + k) % NREQ)]) begin
        pick     = IDW'((int'(last_q) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Select the granted requester's sample; a beat only counts while in BURST.
  always_comb begin
    beat_data = '0;
    beat_vld  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_q) begin
        beat_data = req_data[i*DATAW +: DATAW];
        beat_vld  = req_valid[i] && (state_q == BURST);
      end
    end
  end

  // Only the owner of the current burst sees ready, and only while it is valid.
  always_comb begin
    req_ready = '0;
    if (state_q == BURST) req_ready[grant_q] = req_valid[grant_q];
  end

  // A zero length would never reach its last beat, so it is promoted to one.
  assign len_d     = (cfg_len == '0) ? LENW'(1) : cfg_len;
  assign beat_last = (cnt_q == len_q - LENW'(1));

  // Burst FSM with the registered accumulator-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= IDW'(NREQ - 1);
      len_q        <= '0;
      cnt_q        <= '0;
      acc_data_q   <= '0;
      acc_ivalid_q <= 1'b0;
      acc_first_q  <= 1'b0;
      acc_last_q   <= 1'b0;
    end else begin
      acc_ivalid_q <= 1'b0;
      acc_first_q  <= 1'b0;
      acc_last_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld && !tag_full) begin
            grant_q <= pick;
            last_q  <= pick;
            len_q   <= len_d;
            cnt_q   <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (beat_vld) begin
            acc_data_q   <= beat_data;
            acc_ivalid_q <= 1'b1;
            acc_first_q  <= (cnt_q == '0);
            acc_last_q   <= beat_last;
            cnt_q        <= cnt_q + LENW'(1);
            if (beat_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The tag goes in on the same edge that registers acc_last.
  assign tag_push = beat_vld && beat_last;
  assign tag_pop  = acc_ovalid && !tag_empty;

  tag_fifo #(
    .DEPTH (TAGD),
    .W     (IDW)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .din_i   (grant_q),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  // Result routing; a result with no pending tag is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      res_valid_q <= tag_pop;
      if (tag_pop) begin
        res_data_q <= acc_result;
        res_id_q   <= tag_head;
      end
      if (acc_ovalid && tag_empty) err_orphan_q <= 1'b1;
    end
  end

  assign acc_data   = acc_data_q;
  assign acc_ivalid = acc_ivalid_q;
  assign acc_first  = acc_first_q;
  assign acc_last   = acc_last_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign res_valid  = res_valid_q;
  assign err_orphan = err_orphan_q;
  assign busy       = (state_q == BURST) || (tag_count != '0);

endmodule

// File: tb/tb_accum_arb.sv
// tb_accum_arb: bench for accum_arb with a stand-in accumulator on the acc_*
// ports and a transaction-level model of requesters, bursts and results.
module tb_accum_arb;

  localparam int NREQ   = 4;
  localparam int DATAW  = 19;
  localparam int ACCUMW = 32;
  localparam int LENW   = 8;
  localparam int TAGD   = 4;
  localparam int IDW    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LENW-1:0]        cfg_len;
  logic [NREQ*DATAW-1:0]  req_data;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [DATAW-1:0]       acc_data;
  logic                   acc_ivalid, acc_first, acc_last;
  logic [ACCUMW-1:0]      acc_result;
  logic                   acc_ovalid;
  logic [ACCUMW-1:0]      res_data;
  logic [IDW-1:0]         res_id;
  logic                   res_valid, busy, err_orphan;
  logic                   kick;

  accum_arb #(
    .NREQ(NREQ), .DATAW(DATAW), .ACCUMW(ACCUMW), .LENW(LENW), .TAGD(TAGD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .req_data(req_data),
    .req_valid(req_valid), .req_ready(req_ready), .acc_data(acc_data),
    .acc_ivalid(acc_ivalid), .acc_first(acc_first), .acc_last(acc_last),
    .acc_result(acc_result), .acc_ovalid(acc_ovalid), .res_data(res_data),
    .res_id(res_id), .res_valid(res_valid), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Stand-in accumulator: sums a burst, emits the total one cycle after acc_last.
  logic signed [ACCUMW-1:0] acc_sum_q, acc_ext, next_sum;
  assign acc_ext  = $signed(acc_data);
  assign next_sum = (acc_first ? ACCUMW'(0) : acc_sum_q) + acc_ext;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_q  <= '0;
      acc_ovalid <= 1'b0;
      acc_result <= '0;
    end else begin
      acc_ovalid <= 1'b0;
      if (kick) begin
        acc_ovalid <= 1'b1;
        acc_result <= 32'd123;
      end
      if (acc_ivalid) begin
        acc_sum_q <= next_sum;
        if (acc_last) begin
          acc_ovalid <= 1'b1;
          acc_result <= next_sum;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
  endtask

  // Model state: per-requester sample queues and the burst owner.
  int rq [NREQ][$];
  int exp_id[$], exp_sum[$];
  int seen_id[$], seen_sum[$];
  bit m_burst;
  int owner, last_owner, beat_idx, m_sum, m_len;
  int gap_hold, gap_after, gap_n;
  bit rand_gaps;

  function automatic int rr_next(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_id.delete();
    exp_sum.delete();
    m_burst    = 1'b0;
    owner      = 0;
    last_owner = NREQ - 1;
    beat_idx   = 0;
    m_sum      = 0;
    m_len      = 1;
    gap_hold   = 0;
    gap_after  = -1;
    gap_n      = 0;
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs #1 after.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    bit beat;
    bit bfirst, blast;
    int bdata, ei, es;
    beat = 1'b0; bfirst = 1'b0; blast = 1'b0; bdata = 0;
    @(negedge clk);
    if (rand_gaps && m_burst && gap_hold == 0 && $urandom_range(0, 3) == 0)
      gap_hold = $urandom_range(1, 2);
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0 && !(m_burst && i == owner && gap_hold > 0)) begin
        req_valid[i] = 1'b1;
        req_data[i*DATAW +: DATAW] = DATAW'(rq[i][0]);
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DATAW +: DATAW] = DATAW'($urandom);
      end
    end
    if (m_burst && gap_hold > 0) gap_hold--;
    #1;
    exp_ready = '0;
    if (m_burst) exp_ready[owner] = req_valid[owner];
    check("req_ready", req_ready, exp_ready);
    if (m_burst) begin
      if (req_valid[owner]) begin
        beat   = 1'b1;
        bdata  = rq[owner].pop_front();
        bfirst = (beat_idx == 0);
        blast  = (beat_idx == m_len - 1);
        m_sum += bdata;
        if (beat_idx == gap_after && !blast) gap_hold = gap_n;
        beat_idx++;
        if (blast) begin
          exp_id.push_back(owner);
          exp_sum.push_back(m_sum);
          m_burst    = 1'b0;
          last_owner = owner;
        end
      end
    end else if (req_valid != '0) begin
      owner    = rr_next(last_owner, req_valid);
      m_burst  = 1'b1;
      beat_idx = 0;
      m_sum    = 0;
      m_len    = (cfg_len == '0) ? 1 : int'(cfg_len);
    end
    @(posedge clk);
    #1;
    if (beat)
      check("acc_beat", {acc_ivalid, acc_first, acc_last, acc_data},
            {1'b1, bfirst, blast, DATAW'(bdata)});
    else
      check("acc_idle", acc_ivalid, 0);
    if (res_valid) begin
      if (exp_id.size() == 0) begin
        check("res_unexpected", res_valid, 0);
      end else begin
        ei = exp_id.pop_front();
        es = exp_sum.pop_front();
        check("res_id", res_id, ei);
        check("res_data", $signed(res_data), es);
      end
      seen_id.push_back(int'(res_id));
      seen_sum.push_back(int'($signed(res_data)));
    end
    check("busy", busy, (m_burst || exp_id.size() != 0));
  endtask

  function automatic bit pending();
    bit any;
    any = m_burst || (exp_id.size() != 0);
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (pending() && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) fail_timeout("drain");
    repeat (3) step();
  endtask

  typedef struct packed {
    int id; int len; int n;
    int d0; int d1; int d2; int d3; int d4;
    int gap_after; int gap_n; int exp_sum;
  } vec_t;

  function automatic int getd(input vec_t v, input int k);
    case (k)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      3: return v.d3;
      default: return v.d4;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int c, nb, ln;
    vecs[0] = '{2, 3, 3, 10, 20, 30, 0, 0, -1, 0, 60};
    vecs[1] = '{3, 1, 1, -5, 0, 0, 0, 0, -1, 0, -5};
    vecs[2] = '{1, 3, 3, 5, 15, -4, 0, 0, 0, 2, 16};
    vecs[3] = '{0, 0, 1, 7, 0, 0, 0, 0, -1, 0, 7};
    vecs[4] = '{1, 4, 4, 262143, 262143, -262144, 5, 0, -1, 0, 262147};

    rst = 1'b0; kick = 1'b0; rand_gaps = 1'b0;
    req_valid = '0; req_data = '0; cfg_len = LENW'(2);
    model_reset();

    // Reset values.
    #3 rst = 1'b1;
    #1;
    check("reset_outputs",
          {acc_ivalid, acc_first, acc_last, res_valid, busy, err_orphan, req_ready, acc_data, res_data, res_id},
          0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All four requesters at once: grant order 0,1,2,3.
    cfg_len = LENW'(2);
    for (int i = 0; i < NREQ; i++) begin
      rq[i].push_back(i + 1);
      rq[i].push_back(i + 1);
    end
    seen_id.delete(); seen_sum.delete();
    drain(200);
    check("rr_count", seen_id.size(), 4);
    for (int i = 0; i < NREQ; i++) begin
      if (i < seen_id.size()) begin
        check("rr_id", seen_id[i], i);
        check("rr_sum", seen_sum[i], 2 * (i + 1));
      end
    end

    // Single-burst vectors.
    for (int v = 0; v < 5; v++) begin
      cfg_len   = LENW'(vecs[v].len);
      gap_after = vecs[v].gap_after;
      gap_n     = vecs[v].gap_n;
      for (int k = 0; k < vecs[v].n; k++) rq[vecs[v].id].push_back(getd(vecs[v], k));
      seen_id.delete(); seen_sum.delete();
      drain(200);
      check("tbl_count", seen_id.size(), 1);
      if (seen_id.size() != 0) begin
        check("tbl_id", seen_id[0], vecs[v].id);
        check("tbl_sum", seen_sum[0], vecs[v].exp_sum);
      end
      gap_after = -1;
    end

    // Reset during beat 2 of 4 aborts the burst.
    cfg_len = LENW'(4);
    for (int k = 0; k < 4; k++) rq[2].push_back(k + 1);
    c = 0;
    while (!(m_burst && beat_idx == 2) && c < 40) begin
      step();
      c++;
    end
    if (c >= 40) fail_timeout("reset_wait");
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("rst_abort", {acc_ivalid, acc_first, acc_last, res_valid, busy, req_ready}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    seen_id.delete(); seen_sum.delete();
    repeat (4) begin
      step();
      check("rst_no_last", acc_last, 0);
    end
    check("rst_no_res", seen_id.size(), 0);
    cfg_len = LENW'(2);
    rq[0].push_back(1); rq[0].push_back(2);
    rq[3].push_back(9); rq[3].push_back(9);
    drain(200);
    check("post_rst_count", seen_id.size(), 2);
    if (seen_id.size() != 0) begin
      check("post_rst_id", seen_id[0], 0);
      check("post_rst_sum", seen_sum[0], 3);
    end

    // Result with no tag outstanding.
    check("orphan_clear", err_orphan, 0);
    seen_id.delete(); seen_sum.delete();
    kick = 1'b1;
    step();
    kick = 1'b0;
    step();
    check("orphan_set", err_orphan, 1);
    repeat (5) step();
    check("orphan_sticky", err_orphan, 1);
    check("orphan_no_res", seen_id.size(), 0);

    // Randomized traffic with random valid gaps.
    rand_gaps = 1'b1;
    for (int r = 0; r < 8; r++) begin
      ln = $urandom_range(0, 5);
      cfg_len = LENW'(ln);
      for (int i = 0; i < NREQ; i++) begin
        nb = $urandom_range(0, 2);
        for (int k = 0; k < nb * ((ln == 0) ? 1 : ln); k++)
          rq[i].push_back(int'($urandom_range(0, 524287)) - 262144);
      end
      drain(400);
    end
    rand_gaps = 1'b0;
    check("orphan_final", err_orphan, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_arb.md
ACCUM_ARB -- requirements
Module: accum_arb

Interface
REQ-001 The block SHALL have parameters NREQ, 4, number of requesters; DATAW, 19, sample width; ACCUMW, 32, result width; LENW, 8, burst-length width; TAGD, 4, tag FIFO depth.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_len  in  LENW  beats per burst
- req_data  in  NREQ x DATAW  signed requester samples
- req_valid  in  NREQ  requester has a sample
- req_ready  out  NREQ  sample accepted this cycle
- acc_data  out  DATAW  signed sample to the accumulator
- acc_ivalid  out  1  sample valid to the accumulator
- acc_first  out  1  first beat of a burst
- acc_last  out  1  last beat of a burst
- acc_result  in  ACCUMW  signed accumulator result
- acc_ovalid  in  1  accumulator result valid
- res_data  out  ACCUMW  routed result
- res_id  out  $clog2(NREQ)  requester owning res_data
- res_valid  out  1  result valid
- busy  out  1  burst in progress or tags outstanding
- err_orphan  out  1  sticky error: result arrived with no tag pending

Function
REQ-003 The FSM SHALL have two states, IDLE and BURST.
REQ-004 In IDLE, if any req_valid is high and the tag FIFO is not full, the FSM SHALL grant the first requesting index after the last granted index (round-robin), latch cfg_len into a beat counter (0 treated as 1), and go to BURST the next cycle.
REQ-005 In BURST, req_ready[grant] SHALL equal req_valid[grant]; every other req_ready bit SHALL be 0.
REQ-006 Each accepted beat SHALL appear on acc_data/acc_ivalid exactly one cycle later (registered).
REQ-007 acc_first SHALL be 1 only with the first accepted beat of a burst; acc_last SHALL be 1 only with beat number len-1; for len=1 both SHALL be 1 on the same beat.
REQ-008 Cycles in BURST with req_valid[grant]=0 SHALL produce acc_ivalid=0 and SHALL NOT advance the beat count.
REQ-009 When acc_last is registered, the grant index SHALL be pushed into the tag FIFO and the FSM SHALL return to IDLE; at least one IDLE cycle SHALL separate bursts.
REQ-010 On acc_ovalid, the FSM SHALL pop the tag FIFO; one cycle later it SHALL drive res_valid=1, res_data=acc_result and res_id=the popped tag.
REQ-011 A push and a pop in the same cycle SHALL both succeed, leaving the tag count unchanged.
REQ-012 acc_ovalid with the tag FIFO empty SHALL set err_orphan (until reset) and SHALL produce no res_valid.
REQ-013 busy SHALL be (state==BURST) OR (tag count != 0).
REQ-014 Data SHALL pass through unmodified; sign handling and width growth belong to the accumulator.

Reset
REQ-015 Asserting rst SHALL immediately force: state IDLE; round-robin pointer set so requester 0 wins first; tag FIFO empty; all outputs 0.
REQ-016 rst asserted mid-burst SHALL abort the burst with no acc_last and no tag push.

Structure
REQ-017 Package accum_arb_pkg SHALL hold the state enum, default parameter constants and the ID width function/constant.
REQ-018 The tag FIFO SHALL be a sub-module, tag_fifo (depth TAGD, width ID, push/pop/full/empty/count).

Verification
REQ-019 The bench SHALL attach the team's accum (DATAW=19, ACCUMW=32) to the acc_* ports and SHALL cover:
- Single requester 2, len=3, data 10,20,30 -> one res_valid, res_id=2, res_data=60.
- Requesters 0..3 all valid, len=2, data = id+1 each beat -> grant order 0,1,2,3; results 2,4,6,8 with matching res_id.
- len=1, data -5 -> acc_first=acc_last=1 on the same beat; res_data=-5.
- len=3 on requester 1, req_valid low for 2 cycles mid-burst, data 5,x,x,15,-4 -> res_data=16; the gap does not advance the count.
- rst pulse during beat 2 of 4 -> no acc_last, no res_valid; after reset, requester 0 is granted first and the next burst 1+2 gives 3.
- acc_ovalid forced with no tag outstanding -> err_orphan=1 and stays 1; res_valid stays 0.
